prbs_gen_chk: RTL and testbench

PRBS_GEN_CHK -- requirements
Module: prbs_gen_chk

---
 rtl/prbs_pkg.sv | 59 +++++
 rtl/prbs_lfsr_step.sv | 33 +++
 rtl/prbs_gen_chk.sv | 188 ++++++++++++++++++
 tb/tb_prbs_gen_chk.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: polynomial select encoding, tap/length
// constants, LFSR feedback/mask helpers and a popcount function.
package prbs_pkg;

  typedef enum logic [1:0] {
    PRBS7  = 2'd0,
    PRBS15 = 2'd1,
    PRBS23 = 2'd2,
    PRBS31 = 2'd3
  } poly_t;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } chk_state_t;

  localparam int LFSR_W = 31;

  // Polynomial x^LEN + x^TAP + 1
  localparam int P7_LEN  = 7;
  localparam int P7_TAP  = 6;
  localparam int P15_LEN = 15;
  localparam int P15_TAP = 14;
  localparam int P23_LEN = 23;
  localparam int P23_TAP = 18;
  localparam int P31_LEN = 31;
  localparam int P31_TAP = 28;

  // Feedback bit of the Fibonacci LFSR; this is also the next output bit.
  function automatic logic lfsr_fb(input logic [LFSR_W-1:0] s, input poly_t p);
    case (p)
      PRBS7:   return s[P7_LEN-1]  ^ s[P7_TAP-1];
      PRBS15:  return s[P15_LEN-1] ^ s[P15_TAP-1];
      PRBS23:  return s[P23_LEN-1] ^ s[P23_TAP-1];
      default: return s[P31_LEN-1] ^ s[P31_TAP-1];
    endcase
  endfunction

  // Ones in every LFSR bit above the active polynomial length.
  function automatic logic [LFSR_W-1:0] unused_mask(input poly_t p);
    case (p)
      PRBS7:   return ~((LFSR_W'(1) << P7_LEN)  - LFSR_W'(1));
      PRBS15:  return ~((LFSR_W'(1) << P15_LEN) - LFSR_W'(1));
      PRBS23:  return ~((LFSR_W'(1) << P23_LEN) - LFSR_W'(1));
      default: return '0;
    endcase
  endfunction

  // Number of set bits in a word of up to 64 bits.
  function automatic logic [6:0] popcount(input logic [63:0] v);
    logic [6:0] cnt;
    cnt = '0;
    for (int i = 0; i < 64; i++) begin
      cnt = cnt + 7'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/prbs_lfsr_step.sv
// Combinational DATA_WIDTH-step advance of a 31-bit Fibonacci LFSR.
// pred[i] is the bit the LFSR produces at step i (bit 0 oldest). With
// use_din=1 the external bits are shifted in instead (self-synchronising).
import prbs_pkg::*;

module prbs_lfsr_step #(
  parameter int DATA_WIDTH = 16
) (
  input  logic [LFSR_W-1:0]     state_in,
  input  poly_t                 poly,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  use_din,
  output logic [DATA_WIDTH-1:0] pred,
  output logic [LFSR_W-1:0]     state_out
);

  logic [LFSR_W-1:0] hold_mask;
  logic [LFSR_W-1:0] s;

  assign hold_mask = unused_mask(poly);

  // Unrolled shift chain; bits above the polynomial length stay at one.
  always_comb begin
    s    = state_in;
    pred = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      pred[i] = lfsr_fb(s, poly);
      s = {s[LFSR_W-2:0], (use_din ? din[i] : pred[i])} | hold_mask;
    end
    state_out = s;
  end

endmodule

// File: rtl/prbs_gen_chk.sv
// PRBS generator and checker with lock FSM and saturating bit-error count.
// Optional feature macro: PRBS_ERR_INJECT_EN adds input inject_err, which
// inverts bit 0 of the next generated word.
import prbs_pkg::*;

module prbs_gen_chk #(
  parameter int DATA_WIDTH = 16,
  parameter int ERR_CNT_W  = 32,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            poly_sel,
  input  logic                  gen_en,
  output logic [DATA_WIDTH-1:0] gen_data,
  output logic                  gen_valid,
  input  logic                  chk_valid,
  input  logic [DATA_WIDTH-1:0] chk_data,
  input  logic                  clr_cnt,
`ifdef PRBS_ERR_INJECT_EN
  input  logic                  inject_err,
`endif
  output logic                  chk_locked,
  output logic                  chk_err,
  output logic [ERR_CNT_W-1:0]  err_cnt,
  output logic                  err_sticky
);

  localparam int LOCK_W   = $clog2(LOCK_CNT + 1);
  localparam int UNLOCK_W = $clog2(UNLOCK_CNT + 1);
  localparam int SUM_W    = ((ERR_CNT_W > 7) ? ERR_CNT_W : 7) + 1;
  localparam logic [SUM_W-1:0] ERR_MAX = (SUM_W'(1) << ERR_CNT_W) - SUM_W'(1);

  poly_t                 poly;
  poly_t                 poly_reg;
  logic                  resync;
  logic [LFSR_W-1:0]     gen_lfsr_reg, gen_lfsr_next;
  logic [LFSR_W-1:0]     chk_lfsr_reg, chk_lfsr_next;
  logic [DATA_WIDTH-1:0] gen_word, chk_pred, mismatch, inject_mask;
  logic                  word_err;
  chk_state_t            state_reg, state_next;
  logic [LOCK_W-1:0]     clean_reg, clean_next;
  logic [UNLOCK_W-1:0]   bad_reg, bad_next;
  logic [6:0]            mismatch_pc;
  logic [SUM_W-1:0]      err_sum;
  logic                  count_en;

  assign poly   = poly_t'(poly_sel);
  assign resync = (poly != poly_reg);

  prbs_lfsr_step #(.DATA_WIDTH(DATA_WIDTH)) u_gen_step (
    .state_in  (gen_lfsr_reg),
    .poly      (poly),
    .din       ('0),
    .use_din   (1'b0),
    .pred      (gen_word),
    .state_out (gen_lfsr_next)
  );

  prbs_lfsr_step #(.DATA_WIDTH(DATA_WIDTH)) u_chk_step (
    .state_in  (chk_lfsr_reg),
    .poly      (poly),
    .din       (chk_data),
    .use_din   (state_reg == SEARCH),
    .pred      (chk_pred),
    .state_out (chk_lfsr_next)
  );

  assign mismatch    = chk_pred ^ chk_data;
  assign word_err    = |mismatch;
  assign mismatch_pc = popcount(64'(mismatch));
  assign chk_locked  = (state_reg == LOCKED);

`ifdef PRBS_ERR_INJECT_EN
  logic inject_pend_reg;

  // Remember an injection request until the next word is generated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 inject_pend_reg <= 1'b0;
    else if (gen_en && !resync) inject_pend_reg <= 1'b0;
    else if (inject_err)        inject_pend_reg <= 1'b1;
  end

  assign inject_mask = DATA_WIDTH'(inject_err | inject_pend_reg);
`else
  assign inject_mask = '0;
`endif

  // Registered copy of poly_sel; any difference triggers a resync.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) poly_reg <= PRBS31;
    else        poly_reg <= poly;
  end

  // Generator: advance one word per gen_en, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gen_lfsr_reg <= '1;
      gen_data     <= '0;
      gen_valid    <= 1'b0;
    end else begin
      gen_valid <= gen_en;
      if (resync) begin
        gen_lfsr_reg <= '1;
      end else if (gen_en) begin
        gen_lfsr_reg <= gen_lfsr_next;
        gen_data     <= gen_word ^ inject_mask;
      end
    end
  end

  // Lock FSM next state and streak counters.
  always_comb begin
    state_next = state_reg;
    clean_next = clean_reg;
    bad_next   = bad_reg;
    if (resync) begin
      state_next = SEARCH;
      clean_next = '0;
      bad_next   = '0;
    end else if (chk_valid) begin
      case (state_reg)
        SEARCH: begin
          if (word_err) begin
            clean_next = '0;
          end else if (clean_reg == LOCK_W'(LOCK_CNT - 1)) begin
            state_next = LOCKED;
            clean_next = '0;
            bad_next   = '0;
          end else begin
            clean_next = clean_reg + 1'b1;
          end
        end
        default: begin
          if (!word_err) begin
            bad_next = '0;
          end else if (bad_reg == UNLOCK_W'(UNLOCK_CNT - 1)) begin
            state_next = SEARCH;
            bad_next   = '0;
            clean_next = '0;
          end else begin
            bad_next = bad_reg + 1'b1;
          end
        end
      endcase
    end
  end

  // Checker state: FSM, streaks, checker LFSR and per-word error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= SEARCH;
      clean_reg    <= '0;
      bad_reg      <= '0;
      chk_lfsr_reg <= '1;
      chk_err      <= 1'b0;
    end else begin
      state_reg <= state_next;
      clean_reg <= clean_next;
      bad_reg   <= bad_next;
      if (resync) begin
        chk_lfsr_reg <= '1;
      end else if (chk_valid) begin
        chk_lfsr_reg <= chk_lfsr_next;
        chk_err      <= word_err;
      end
    end
  end

  assign count_en = chk_valid && (state_reg == LOCKED) && !resync;
  assign err_sum  = SUM_W'(err_cnt) + SUM_W'(mismatch_pc);

  // Saturating error counter and sticky flag; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt    <= '0;
      err_sticky <= 1'b0;
    end else if (clr_cnt) begin
      err_cnt    <= '0;
      err_sticky <= 1'b0;
    end else if (count_en) begin
      err_cnt <= (err_sum > ERR_MAX) ? '1 : err_sum[ERR_CNT_W-1:0];
      if (word_err) err_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_prbs_gen_chk.sv
// Directed bench for prbs_gen_chk in loopback. Instance a uses a 32-bit
// error counter, instance b a 4-bit one; both check the same received stream.
// Define PRBS_ERR_INJECT_EN to also exercise inject_err.
module tb_prbs_gen_chk;

  localparam int W      = 16;
  localparam int NWORDS = 130;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    poly_sel;
  logic          gen_en;
  logic          clr_cnt;
  logic          zero_word;
  logic [W-1:0]  flip;
  logic [W-1:0]  chk_data;
  logic [W-1:0]  gen_data_a, gen_data_b;
  logic          gen_valid_a, gen_valid_b;
  logic          locked_a, locked_b, err_a, err_b, sticky_a, sticky_b;
  logic [31:0]   cnt_a;
  logic [3:0]    cnt_b;
`ifdef PRBS_ERR_INJECT_EN
  logic          inject_err;
`endif

  int            vectors    = 0;
  int            miscompares = 0;
  logic [30:0]   m_state;
  logic [1:0]    m_poly;
  logic [W-1:0]  cur_word;
  logic          inj_exp;
  logic [W*NWORDS-1:0] stream;

  assign chk_data = zero_word ? '0 : (gen_data_a ^ flip);

  always #5 clk = ~clk;

  prbs_gen_chk #(.DATA_WIDTH(W), .ERR_CNT_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .poly_sel(poly_sel), .gen_en(gen_en),
    .gen_data(gen_data_a), .gen_valid(gen_valid_a),
    .chk_valid(gen_valid_a), .chk_data(chk_data), .clr_cnt(clr_cnt),
`ifdef PRBS_ERR_INJECT_EN
    .inject_err(inject_err),
`endif
    .chk_locked(locked_a), .chk_err(err_a), .err_cnt(cnt_a), .err_sticky(sticky_a)
  );

  prbs_gen_chk #(.DATA_WIDTH(W), .ERR_CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .poly_sel(poly_sel), .gen_en(gen_en),
    .gen_data(gen_data_b), .gen_valid(gen_valid_b),
    .chk_valid(gen_valid_a), .chk_data(chk_data), .clr_cnt(clr_cnt),
`ifdef PRBS_ERR_INJECT_EN
    .inject_err(inject_err),
`endif
    .chk_locked(locked_b), .chk_err(err_b), .err_cnt(cnt_b), .err_sticky(sticky_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bit-serial reference: y[k] = y[k-LEN] ^ y[k-TAP], seeded with ones.
  task automatic model_advance(output logic [W-1:0] w);
    int  n, t;
    logic b;
    case (m_poly)
      2'd0:    begin n = 7;  t = 6;  end
      2'd1:    begin n = 15; t = 14; end
      2'd2:    begin n = 23; t = 18; end
      default: begin n = 31; t = 28; end
    endcase
    for (int i = 0; i < W; i++) begin
      b = m_state[n-1] ^ m_state[t-1];
      w[i] = b;
      m_state = {m_state[29:0], b};
    end
  endtask

  // One clock; outputs sampled 1 time unit after the rising edge.
  task automatic tick();
    logic en;
    en = gen_en;
    @(posedge clk);
    #1;
    check("gen_valid", gen_valid_a, en);
    if (en) begin
      model_advance(cur_word);
      cur_word[0] = cur_word[0] ^ inj_exp;
      inj_exp = 1'b0;
      check("gen_data", gen_data_a, cur_word);
      check("gen_data_b", gen_data_b, cur_word);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pc;
    int base_a;
    int exp_b;
    int errs;
    rst_n = 1'b0; poly_sel = 2'd3; gen_en = 1'b0; clr_cnt = 1'b0;
    zero_word = 1'b0; flip = '0; inj_exp = 1'b0;
`ifdef PRBS_ERR_INJECT_EN
    inject_err = 1'b0;
`endif
    m_state = '1; m_poly = 2'd3; cur_word = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_gen_data", gen_data_a, 0);
    check("rst_gen_valid", gen_valid_a, 0);
    check("rst_locked", locked_a, 0);
    check("rst_chk_err", err_a, 0);
    check("rst_err_cnt", cnt_a, 0);
    check("rst_sticky", sticky_a, 0);
    check("rst_err_cnt_b", cnt_b, 0);
    $display("step reset: gen_data=%h locked=%0d err_cnt=%0d", gen_data_a, locked_a, cnt_a);

    // PRBS31 loopback from reset; lock one cycle after the 16th word
    rst_n = 1'b1;
    tick();
    gen_en = 1'b1;
    tick();
    check("prbs31_word0", gen_data_a, 16'h0000);
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 15) begin
        check("prbs31_unlocked_15", locked_a, 0);
        check("prbs31_unlocked_15_b", locked_b, 0);
      end
      if (k == 16) begin
        check("prbs31_locked_16", locked_a, 1);
        check("prbs31_locked_16_b", locked_b, 1);
      end
    end
    $display("step lock31: locked=%0d err_cnt=%0d", locked_a, cnt_a);

    for (int k = 0; k < 10000; k++) tick();
    check("run_err_cnt", cnt_a, 0);
    check("run_chk_err", err_a, 0);
    check("run_locked", locked_a, 1);
    check("run_sticky", sticky_a, 0);
    $display("step run10000: locked=%0d err_cnt=%0d", locked_a, cnt_a);

    // Single bit 5 flip while locked
    flip = 16'h0020;
    tick();
    flip = '0;
    check("flip5_chk_err", err_a, 1);
    check("flip5_err_cnt", cnt_a, 1);
    check("flip5_sticky", sticky_a, 1);
    check("flip5_locked", locked_a, 1);
    tick();
    check("flip5_chk_err_after", err_a, 0);
    check("flip5_err_cnt_after", cnt_a, 1);
    check("flip5_locked_after", locked_a, 1);
    $display("step flip5: err_cnt=%0d sticky=%0d locked=%0d", cnt_a, sticky_a, locked_a);

    // Four all-zero words drop lock; relock after 16 clean words
    base_a = 1;
    pc = 0;
    zero_word = 1'b1;
    for (int z = 1; z <= 4; z++) begin
      pc += $countones(cur_word);
      tick();
      if (z < 4) check("zero_still_locked", locked_a, 1);
      check("zero_chk_err", err_a, 1);
    end
    zero_word = 1'b0;
    exp_b = (base_a + pc > 15) ? 15 : base_a + pc;
    check("zero_unlocked", locked_a, 0);
    check("zero_err_cnt", cnt_a, base_a + pc);
    check("zero_err_cnt_b", cnt_b, exp_b);
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 8 || k == 15) check("search_err_cnt_hold", cnt_a, base_a + pc);
      if (k == 15) check("relock_not_yet", locked_a, 0);
      if (k == 16) check("relock_16", locked_a, 1);
    end
    $display("step zero4: err_cnt=%0d locked=%0d", cnt_a, locked_a);

    // Saturation on the 4-bit counter, clear priority
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check("clr_err_cnt", cnt_a, 0);
    check("clr_err_cnt_b", cnt_b, 0);
    check("clr_sticky", sticky_a, 0);
    flip = 16'h1FFF;
    tick();
    flip = '0;
    check("pre13_err_cnt", cnt_a, 13);
    check("pre13_err_cnt_b", cnt_b, 13);
    tick();
    flip = 16'hFFFF;
    tick();
    flip = '0;
    check("sat_err_cnt_b", cnt_b, 15);
    check("sat_err_cnt", cnt_a, 29);
    tick();
    check("sat_hold_b", cnt_b, 15);
    flip = 16'hFFFF;
    clr_cnt = 1'b1;
    tick();
    flip = '0;
    clr_cnt = 1'b0;
    check("clr_vs_err_cnt", cnt_a, 0);
    check("clr_vs_err_cnt_b", cnt_b, 0);
    check("clr_vs_err_sticky_b", sticky_b, 0);
    check("clr_vs_err_chk_err", err_a, 1);
    tick();
    check("sat_still_locked", locked_a, 1);
    $display("step saturate: err_cnt_b=%0d locked=%0d", cnt_b, locked_a);

    // Poly change 3 -> 0 while locked
    flip = 16'h0001;
    tick();
    flip = '0;
    tick();
    check("pre_poly_err_cnt", cnt_a, 1);
    poly_sel = 2'd0;
    gen_en = 1'b0;
    tick();
    check("poly_unlocked", locked_a, 0);
    check("poly_err_cnt_kept", cnt_a, 1);
    m_state = '1;
    m_poly = 2'd0;
    gen_en = 1'b1;
    tick();
    check("prbs7_word0", gen_data_a, 16'h3040);
    stream[0 +: W] = gen_data_a;
    for (int k = 1; k < NWORDS; k++) begin
      tick();
      stream[k*W +: W] = gen_data_a;
      if (k == 15) check("prbs7_unlocked_15", locked_a, 0);
      if (k == 16) check("prbs7_locked_16", locked_a, 1);
    end
    errs = 0;
    for (int i = 0; i + 127 < W*NWORDS; i++) begin
      if (stream[i] !== stream[i+127]) errs++;
    end
    check("prbs7_period127", errs, 0);
    check("prbs7_ones_per_period", $countones(stream[126:0]), 64);
    check("prbs7_err_cnt", cnt_a, 1);
    $display("step prbs7: locked=%0d err_cnt=%0d period_errs=%0d", locked_a, cnt_a, errs);

`ifdef PRBS_ERR_INJECT_EN
    // Single injected error
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    inject_err = 1'b1;
    inj_exp = 1'b1;
    tick();
    inject_err = 1'b0;
    tick();
    check("inject_chk_err", err_a, 1);
    check("inject_err_cnt", cnt_a, 1);
    for (int k = 0; k < 4; k++) tick();
    check("inject_err_cnt_after", cnt_a, 1);
    check("inject_chk_err_after", err_a, 0);
    check("inject_locked", locked_a, 1);
    $display("step inject: err_cnt=%0d locked=%0d", cnt_a, locked_a);
`endif

    // Asynchronous reset mid-stream
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_locked", locked_a, 0);
    check("midrst_err_cnt", cnt_a, 0);
    check("midrst_gen_data", gen_data_a, 0);
    check("midrst_chk_err", err_a, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    $display("step midreset: locked=%0d err_cnt=%0d", locked_a, cnt_a);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
